data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//   Word-organised data memory for the single-cycle CPU datapath, serving load/store.
//   Byte-addressed 32-bit interface, word-aligned accesses only.
//   Combinational read; synchronous write on rising clk.
//   Misaligned or out-of-range accesses read as zero; misaligned or out-of-range writes are dropped.
// PARAMETERS
//   MEM_BYTES   1024   total capacity in bytes; multiple of 4, >= 8
//   ADDR_W      32     address port width
//   DATA_W      32     data word width (fixed at 32)
// PORTS
//   clk         in   1    clock, rising-edge active
//   rst         in   1    reset, asynchronous, active-high
//   write_en    in   1    store strobe, sampled on rising clk
//   addr        in   32   byte address
//   write_data  in   32   store data
//   read_data   out  32   load data, combinational
// BEHAVIOUR
//   Storage: MEM_BYTES/4 words, each 32 bits. Word index = addr[31:2].
//   valid = (addr[1:0] == 2'b00) && (addr <= MEM_BYTES-4).
//   Compare the full 32-bit addr, so no wrap or aliasing occurs above MEM_BYTES.
//   Read:
//     - read_data = valid ? mem[addr>>2] : 32'h0.
//     - Purely combinational, zero-cycle latency.
//     - Follows addr and memory contents within the same cycle.
//   Write: at posedge clk, if write_en && valid && !rst, mem[addr>>2] <= write_data.
//     - write_en with an invalid addr has no effect on any word.
//   Same-cycle write and read of one word:
//     - read_data shows the old value before the edge.
//     - read_data shows write_data immediately after the edge.
//   Reset:
//     - rst high clears every word to 0 asynchronously.
//     - Words stay 0 while rst is asserted.
//     - Writes are ignored while rst is high.
//     - read_data is 0 during reset.
//   Deassertion of rst mid-cycle: the first write takes effect at the next posedge with rst low.
//   No byte or halfword stores. No handshake. Memory is always ready.
//   X or Z on addr must not corrupt stored words when write_en is 0.
// TESTING
//   1. Pulse rst. Set addr=0x00 with write_en=0 -> read_data = 0x00000000.
//   2. Write addr=0x04, data=0xDEADBEEF for one clk. Then read 0x04 -> 0xDEADBEEF.
//      Read 0x00 -> 0x00000000.
//   3. Misaligned read at addr=0x05 -> 0x00000000. Write 0x12345678 to 0x05.
//      Then 0x04 still reads 0xDEADBEEF.
//   4. Out-of-range read at addr=MEM_BYTES -> 0x00000000.
//      Write to MEM_BYTES or 0xFFFFFFFC -> no word changes; address 0x00 still reads 0.
//   5. Write 0xAABBCCDD to MEM_BYTES-4 -> read back 0xAABBCCDD.
//      Address MEM_BYTES-8 is unaffected.
//   6. Assert rst asynchronously between clock edges after the writes above.
//      -> 0x04 and MEM_BYTES-4 read 0 immediately.
//      -> A write attempted while rst is high is ignored.

Source files
------------

// File: rtl/data_mem_if.sv
// Load/store bus between the CPU datapath and data memory.
// The master drives the address, write strobe and data; the slave returns read data.
interface data_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              write_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  modport master (
    output write_en,
    output addr,
    output write_data,
    input  read_data
  );

  modport slave (
    input  write_en,
    input  addr,
    input  write_data,
    output read_data
  );
endinterface

// File: rtl/data_mem.sv
// Word-organised data memory: byte-addressed, word-aligned only, combinational read,
// synchronous write, asynchronous clear. Misaligned/out-of-range accesses read 0 and never write.
module data_mem #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus
);
  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic              w_valid;
  logic [IDX_W-1:0]  w_idx;

  // Full-width compare so addresses above the array never alias into it.
  always_comb begin
    w_valid = (bus.addr[1:0] == 2'b00) && (bus.addr <= ADDR_W'(MEM_BYTES - 4));
    w_idx   = bus.addr[IDX_W+1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.write_en && w_valid) begin
      r_mem[w_idx] <= bus.write_data;
    end
  end

  always_comb begin
    bus.read_data = '0;
    if (w_valid && !rst) begin
      bus.read_data = r_mem[w_idx];
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// Randomized self-checking bench for data_mem against a word-array reference model.
module tb_data_mem;
  localparam int MEM_BYTES = 1024;

  logic clk = 1'b0;
  logic rst;

  data_mem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  data_mem #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] ref_mem [MEM_BYTES/4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_valid(input logic [31:0] a);
    return (a % 4 == 0) && (a <= MEM_BYTES - 4);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_valid(a)) return ref_mem[a / 4];
    return 32'h0;
  endfunction

  task automatic ref_clear();
    foreach (ref_mem[i]) ref_mem[i] = 32'h0;
  endtask

  // One bus cycle: drive after the falling edge, check before and after the rising edge.
  task automatic access(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] d);
    @(negedge clk);
    bus.write_en   = we;
    bus.addr       = a;
    bus.write_data = d;
    #1 chk({tag, "_pre"}, bus.read_data, ref_read(a));
    @(posedge clk);
    if (we && !rst && ref_valid(a)) ref_mem[a / 4] = d;
    #1 chk({tag, "_post"}, bus.read_data, ref_read(a));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int unsigned sel;

    rst = 1'b1;
    bus.write_en = 1'b0;
    bus.addr = '0;
    bus.write_data = '0;
    ref_clear();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    access("reset_rd0", 1'b0, 32'h0, 32'h0);
    access("wr4", 1'b1, 32'h4, 32'hDEADBEEF);
    access("rd4", 1'b0, 32'h4, 32'h0);
    access("rd0", 1'b0, 32'h0, 32'h0);
    access("misal_rd5", 1'b0, 32'h5, 32'h0);
    access("misal_wr5", 1'b1, 32'h5, 32'h12345678);
    access("rd4_after_misal", 1'b0, 32'h4, 32'h0);
    access("oor_rd", 1'b0, MEM_BYTES, 32'h0);
    access("oor_wr", 1'b1, MEM_BYTES, 32'h11111111);
    access("oor_wr_top", 1'b1, 32'hFFFF_FFFC, 32'h22222222);
    access("rd0_after_oor", 1'b0, 32'h0, 32'h0);
    access("wr_last", 1'b1, MEM_BYTES - 4, 32'hAABBCCDD);
    access("rd_last", 1'b0, MEM_BYTES - 4, 32'h0);
    access("rd_last_m8", 1'b0, MEM_BYTES - 8, 32'h0);

    // Unknown address with write_en low must not disturb storage.
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.addr = 'x;
    bus.write_data = 32'hBAD0BAD0;
    @(posedge clk);
    access("rd4_after_x", 1'b0, 32'h4, 32'h0);

    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3)      a = $urandom_range(0, 15) * 4;
      else if (sel <= 6) a = $urandom_range(0, MEM_BYTES / 4 - 1) * 4;
      else if (sel == 7) a = ($urandom_range(0, MEM_BYTES / 4 - 1) * 4) | $urandom_range(1, 3);
      else if (sel == 8) a = MEM_BYTES + $urandom_range(0, 1000) * 4;
      else               a = $urandom;
      d = $urandom;
      access("rand", 1'($urandom_range(0, 1)), a, d);
    end

    access("pre_rst_wr4", 1'b1, 32'h4, 32'hDEADBEEF);
    access("pre_rst_wrlast", 1'b1, MEM_BYTES - 4, 32'hAABBCCDD);

    // Asynchronous reset between edges.
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.addr = 32'h4;
    #1 chk("pre_rst_rd4", bus.read_data, ref_read(32'h4));
    #1 rst = 1'b1;
    ref_clear();
    #1 chk("rst_rd4", bus.read_data, 32'h0);
    bus.addr = MEM_BYTES - 4;
    #1 chk("rst_rdlast", bus.read_data, 32'h0);
    bus.write_en = 1'b1;
    bus.addr = 32'h8;
    bus.write_data = 32'h55;
    @(posedge clk);
    #1 chk("rst_wr_ignored", bus.read_data, 32'h0);
    #1 rst = 1'b0;
    bus.write_en = 1'b0;
    #1 chk("post_rst_rd8", bus.read_data, 32'h0);
    access("post_rst_rd4", 1'b0, 32'h4, 32'h0);
    access("post_rst_rdlast", 1'b0, MEM_BYTES - 4, 32'h0);
    access("post_rst_wr8", 1'b1, 32'h8, 32'h55);
    access("post_rst_rd8b", 1'b0, 32'h8, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
